// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings for the hazard/stall controller: forward selects, FSM states, register zero.
package hazard_stall_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] RUN     = 2'b00;
    localparam logic [1:0] LDSTALL = 2'b01;
    localparam logic [1:0] MDUWAIT = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle seen by the hazard controller: stage register fields in, stall/flush/forward controls out.
interface hazard_stall_ctrl_if;

    logic [4:0] Rs_ID;
    logic [4:0] Rt_ID;
    logic       UseRs_ID;
    logic       UseRt_ID;
    logic       MemToReg_Ex;
    logic       RegWr_Ex;
    logic [4:0] Dst_Ex;
    logic [4:0] Rs_Ex;
    logic [4:0] Rt_Ex;
    logic       RegWr_Mem;
    logic [4:0] Dst_Mem;
    logic       RegWr_Wb;
    logic [4:0] Dst_Wb;
    logic       MduStart_Ex;
    logic       BranchTaken_Ex;
    logic       Jump_Ex;

    logic       PC_Wr;
    logic       stall_IF_ID;
    logic       stall_ID_EX;
    logic       bubble_EX;
    logic       flush_IF_ID;
    logic [1:0] ForwardA;
    logic [1:0] ForwardB;
    logic       mdu_busy;

    modport slave (
        input  Rs_ID, Rt_ID, UseRs_ID, UseRt_ID, MemToReg_Ex, RegWr_Ex, Dst_Ex,
               Rs_Ex, Rt_Ex, RegWr_Mem, Dst_Mem, RegWr_Wb, Dst_Wb,
               MduStart_Ex, BranchTaken_Ex, Jump_Ex,
        output PC_Wr, stall_IF_ID, stall_ID_EX, bubble_EX, flush_IF_ID,
               ForwardA, ForwardB, mdu_busy
    );

    modport master (
        output Rs_ID, Rt_ID, UseRs_ID, UseRt_ID, MemToReg_Ex, RegWr_Ex, Dst_Ex,
               Rs_Ex, Rt_Ex, RegWr_Mem, Dst_Mem, RegWr_Wb, Dst_Wb,
               MduStart_Ex, BranchTaken_Ex, Jump_Ex,
        input  PC_Wr, stall_IF_ID, stall_ID_EX, bubble_EX, flush_IF_ID,
               ForwardA, ForwardB, mdu_busy
    );

endinterface

// File: rtl/hazard_stall_ctrl_fwd_sel_unit.sv
// Forward select for one Ex operand; the younger Mem result wins over Wb, register zero never forwards.
module fwd_sel_unit
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [4:0] reg_ex,
    input  logic       reg_wr_mem,
    input  logic [4:0] dst_mem,
    input  logic       reg_wr_wb,
    input  logic [4:0] dst_wb,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_REG;
        if (reg_wr_mem && (dst_mem != REG_ZERO) && (dst_mem == reg_ex)) begin
            fwd_sel = FWD_MEM;
        end else if (reg_wr_wb && (dst_wb != REG_ZERO) && (dst_wb == reg_ex)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode->execute handoff control: load-use bubbles, MDU busy hold, wrong-path flush, operand forwarding.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MDU_LATENCY       = 8,
    parameter int CNT_W             = 5
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_ctrl_if.slave  hz
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic loaduse;
    logic redirect;
    logic pc_wr, stall_if_id, stall_id_ex, bubble_ex, flush_if_id, mdu_busy;

    assign loaduse = hz.MemToReg_Ex && hz.RegWr_Ex && (hz.Dst_Ex != REG_ZERO) &&
                     ((hz.UseRs_ID && (hz.Rs_ID == hz.Dst_Ex)) ||
                      (hz.UseRt_ID && (hz.Rt_ID == hz.Dst_Ex)));
    assign redirect = hz.BranchTaken_Ex || hz.Jump_Ex;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_wr       = 1'b1;
        stall_if_id = 1'b0;
        stall_id_ex = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        mdu_busy    = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    flush_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                end else if (hz.MduStart_Ex) begin
                    pc_wr       = 1'b0;
                    stall_if_id = 1'b1;
                    stall_id_ex = 1'b1;
                    mdu_busy    = 1'b1;
                    cnt_d       = CNT_W'(MDU_LATENCY - 1);
                    state_d     = MDUWAIT;
                end else if (loaduse) begin
                    pc_wr       = 1'b0;
                    stall_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                    cnt_d       = CNT_W'(LOAD_STALL_CYCLES - 1);
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = LDSTALL;
                    end
                end
            end
            LDSTALL: begin
                pc_wr       = 1'b0;
                stall_if_id = 1'b1;
                bubble_ex   = 1'b1;
                cnt_d       = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            MDUWAIT: begin
                // cnt==0 is the release cycle: the MDU result is valid and Ex may advance.
                if (cnt_q != '0) begin
                    pc_wr       = 1'b0;
                    stall_if_id = 1'b1;
                    stall_id_ex = 1'b1;
                    mdu_busy    = 1'b1;
                    cnt_d       = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.PC_Wr       = pc_wr;
    assign hz.stall_IF_ID = stall_if_id;
    assign hz.stall_ID_EX = stall_id_ex;
    assign hz.bubble_EX   = bubble_ex;
    assign hz.flush_IF_ID = flush_if_id;
    assign hz.mdu_busy    = mdu_busy;

    fwd_sel_unit u_fwd_a (
        .reg_ex     (hz.Rs_Ex),
        .reg_wr_mem (hz.RegWr_Mem),
        .dst_mem    (hz.Dst_Mem),
        .reg_wr_wb  (hz.RegWr_Wb),
        .dst_wb     (hz.Dst_Wb),
        .fwd_sel    (hz.ForwardA)
    );

    fwd_sel_unit u_fwd_b (
        .reg_ex     (hz.Rt_Ex),
        .reg_wr_mem (hz.RegWr_Mem),
        .dst_mem    (hz.Dst_Mem),
        .reg_wr_wb  (hz.RegWr_Wb),
        .dst_wb     (hz.Dst_Wb),
        .fwd_sel    (hz.ForwardB)
    );

endmodule
